// File: rtl/spu_issue_scoreboard.sv
// Dual-pipe in-order issue scoreboard: per-pipe writeback reservation shift
// registers, RAW/WAW/intra-pair/structural stall logic, and register-table write strobes.

module spu_issue_scoreboard_pipe #(
   parameter int ADDR_W  = 7,
   parameter int MAX_LAT = 7
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [MAX_LAT-1:0]           load_oh,
   input  logic [ADDR_W-1:0]            load_addr,
   output logic [MAX_LAT:0]             slot_v,
   output logic [MAX_LAT:0][ADDR_W-1:0] slot_a
);
   // Slot k commits k cycles from now; an empty slot carries address 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_v <= '0;
         slot_a <= '0;
      end else begin
         for (int k = 0; k < MAX_LAT; k++) begin
            if (load_oh[k]) begin
               slot_v[k] <= 1'b1;
               slot_a[k] <= load_addr;
            end else begin
               slot_v[k] <= slot_v[k+1];
               slot_a[k] <= slot_a[k+1];
            end
         end
         slot_v[MAX_LAT] <= 1'b0;
         slot_a[MAX_LAT] <= '0;
      end
   end
endmodule

module spu_issue_scoreboard #(
   parameter int ADDR_W  = 7,
   parameter int MAX_LAT = 7,
   parameter bit BYPASS  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              even_valid,
   input  logic [ADDR_W-1:0] even_ra_addr,
   input  logic [ADDR_W-1:0] even_rb_addr,
   input  logic [ADDR_W-1:0] even_rc_addr,
   input  logic [2:0]        even_src_use,
   input  logic [ADDR_W-1:0] even_rt_addr,
   input  logic              even_rt_we,
   input  logic [2:0]        even_lat,
   input  logic              odd_valid,
   input  logic [ADDR_W-1:0] odd_ra_addr,
   input  logic [ADDR_W-1:0] odd_rb_addr,
   input  logic [ADDR_W-1:0] odd_rt_st_addr,
   input  logic [2:0]        odd_src_use,
   input  logic [ADDR_W-1:0] odd_rt_addr,
   input  logic              odd_rt_we,
   input  logic [2:0]        odd_lat,
   output logic              even_issue,
   output logic              odd_issue,
   output logic              reg_write_even,
   output logic [ADDR_W-1:0] rt_addr_even,
   output logic              reg_write_odd,
   output logic [ADDR_W-1:0] rt_addr_odd,
   output logic              idle
);
   localparam int NUM_PIPES = 2;
   // With forwarding, a slot-0 write is visible to same-cycle reads.
   localparam int PEND_LO   = BYPASS ? 1 : 0;

   logic [NUM_PIPES-1:0]                        vld, we, issue, haz;
   logic [NUM_PIPES-1:0][2:0]                   src_use, lat_in, lat_eff;
   logic [NUM_PIPES-1:0][2:0][ADDR_W-1:0]       src_a;
   logic [NUM_PIPES-1:0][ADDR_W-1:0]            rt_a;
   logic [NUM_PIPES-1:0][MAX_LAT-1:0]           load_oh;
   logic [NUM_PIPES-1:0][MAX_LAT:0]             slot_v;
   logic [NUM_PIPES-1:0][MAX_LAT:0][ADDR_W-1:0] slot_a;
   logic                                        pair_haz;

   assign vld      = {odd_valid, even_valid};
   assign we       = {odd_rt_we, even_rt_we};
   assign src_use  = {odd_src_use, even_src_use};
   assign lat_in   = {odd_lat, even_lat};
   assign rt_a     = {odd_rt_addr, even_rt_addr};
   assign src_a[0] = {even_ra_addr, even_rb_addr, even_rc_addr};
   assign src_a[1] = {odd_ra_addr, odd_rb_addr, odd_rt_st_addr};
   assign issue    = {odd_issue, even_issue};

   genvar g;
   generate
      for (g = 0; g < NUM_PIPES; g++) begin : g_pipe
         assign lat_eff[g] = (lat_in[g] == 3'd0) ? 3'd1 : lat_in[g];
         assign load_oh[g] = (issue[g] & we[g]) ? (MAX_LAT'(1) << (lat_eff[g] - 3'd1)) : '0;

         spu_issue_scoreboard_pipe #(
            .ADDR_W  (ADDR_W),
            .MAX_LAT (MAX_LAT)
         ) u_pipe (
            .clk       (clk),
            .reset     (reset),
            .load_oh   (load_oh[g]),
            .load_addr (rt_a[g]),
            .slot_v    (slot_v[g]),
            .slot_a    (slot_a[g])
         );
      end
   endgenerate

   always_comb begin
      haz = '0;
      for (int p = 0; p < NUM_PIPES; p++) begin
         for (int q = 0; q < NUM_PIPES; q++) begin
            for (int k = 0; k <= MAX_LAT; k++) begin
               for (int s = 0; s < 3; s++)
                  if (src_use[p][s] && k >= PEND_LO && slot_v[q][k] && slot_a[q][k] == src_a[p][s])
                     haz[p] = 1'b1;
               if (we[p] && k >= 1 && slot_v[q][k] && slot_a[q][k] == rt_a[p])
                  haz[p] = 1'b1;
            end
         end
         // Own slot[L] would shift onto the slot this issue loads.
         if (we[p] && slot_v[p][lat_eff[p]])
            haz[p] = 1'b1;
      end
   end

   always_comb begin
      pair_haz = 1'b0;
      for (int s = 0; s < 3; s++)
         if (src_use[1][s] && src_a[1][s] == rt_a[0])
            pair_haz = 1'b1;
      if (we[1] && rt_a[1] == rt_a[0])
         pair_haz = 1'b1;
      pair_haz = pair_haz & even_issue & we[0];
   end

   assign even_issue     = vld[0] & ~haz[0];
   assign odd_issue      = vld[1] & ~haz[1] & ~pair_haz & (~vld[0] | even_issue);

   assign reg_write_even = slot_v[0][0];
   assign rt_addr_even   = slot_a[0][0];
   assign reg_write_odd  = slot_v[1][0];
   assign rt_addr_odd    = slot_a[1][0];
   assign idle           = ~|slot_v;
endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Bench for spu_issue_scoreboard: directed vector table, reset cases, and a
// random run against a due-cycle write-list model.

module tb_spu_issue_scoreboard;
   localparam int ADDR_W  = 7;
   localparam int MAX_LAT = 7;
   localparam bit BYPASS  = 1'b1;

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] a, b, c;
      logic [2:0]        srcs;
      logic [ADDR_W-1:0] rt;
      logic              we;
      logic [2:0]        lat;
   } ins_t;

   typedef struct {
      bit   rst;
      ins_t e, o;
      bit   ei, oi, rwe;
      int   ae;
      bit   rwo;
      int   ao;
      bit   idl;
   } vec_t;

   typedef struct {
      int                pipe;
      int                due;
      logic [ADDR_W-1:0] addr;
   } wr_t;

   logic clk, reset;
   ins_t e_in, o_in;
   logic even_issue, odd_issue, reg_write_even, reg_write_odd, idle;
   logic [ADDR_W-1:0] rt_addr_even, rt_addr_odd;

   int   n_tests = 0, n_fail = 0, cyc = 0;
   vec_t vt[$];
   wr_t  wq[$];

   spu_issue_scoreboard #(.ADDR_W(ADDR_W), .MAX_LAT(MAX_LAT), .BYPASS(BYPASS)) dut (
      .clk            (clk),
      .reset          (reset),
      .even_valid     (e_in.v),
      .even_ra_addr   (e_in.a),
      .even_rb_addr   (e_in.b),
      .even_rc_addr   (e_in.c),
      .even_src_use   (e_in.srcs),
      .even_rt_addr   (e_in.rt),
      .even_rt_we     (e_in.we),
      .even_lat       (e_in.lat),
      .odd_valid      (o_in.v),
      .odd_ra_addr    (o_in.a),
      .odd_rb_addr    (o_in.b),
      .odd_rt_st_addr (o_in.c),
      .odd_src_use    (o_in.srcs),
      .odd_rt_addr    (o_in.rt),
      .odd_rt_we      (o_in.we),
      .odd_lat        (o_in.lat),
      .even_issue     (even_issue),
      .odd_issue      (odd_issue),
      .reg_write_even (reg_write_even),
      .rt_addr_even   (rt_addr_even),
      .reg_write_odd  (reg_write_odd),
      .rt_addr_odd    (rt_addr_odd),
      .idle           (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_out(input string tag, input bit ei, input bit oi, input bit rwe,
                            input int ae, input bit rwo, input int ao, input bit idl);
      chk({tag, ".even_issue"},     32'(even_issue),     32'(ei));
      chk({tag, ".odd_issue"},      32'(odd_issue),      32'(oi));
      chk({tag, ".reg_write_even"}, 32'(reg_write_even), 32'(rwe));
      chk({tag, ".rt_addr_even"},   32'(rt_addr_even),   32'(ae));
      chk({tag, ".reg_write_odd"},  32'(reg_write_odd),  32'(rwo));
      chk({tag, ".rt_addr_odd"},    32'(rt_addr_odd),    32'(ao));
      chk({tag, ".idle"},           32'(idle),           32'(idl));
   endtask

   function automatic ins_t mk(bit v, int ra, bit [2:0] srcs, int rt, bit we, int lat);
      ins_t i;
      i.v = v; i.a = ADDR_W'(ra); i.b = ADDR_W'(ra); i.c = ADDR_W'(ra);
      i.srcs = srcs; i.rt = ADDR_W'(rt); i.we = we; i.lat = 3'(lat);
      return i;
   endfunction

   task automatic add(input bit rst, input ins_t e, input ins_t o, input bit ei, input bit oi,
                      input bit rwe, input int ae, input bit rwo, input int ao, input bit idl);
      vt.push_back('{rst, e, o, ei, oi, rwe, ae, rwo, ao, idl});
   endtask

   task automatic do_reset();
      e_in  = '0;
      o_in  = '0;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   // ---- reference model: list of writes with their absolute commit cycle ----
   function automatic bit m_pend(logic [ADDR_W-1:0] x);
      foreach (wq[i])
         if (wq[i].addr == x && (wq[i].due > cyc || (!BYPASS && wq[i].due == cyc))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_waw(logic [ADDR_W-1:0] x);
      foreach (wq[i]) if (wq[i].addr == x && wq[i].due > cyc) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_busy(int p, int due);
      foreach (wq[i]) if (wq[i].pipe == p && wq[i].due == due) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int leff(logic [2:0] l);
      return (l == 3'd0) ? 1 : int'(l);
   endfunction

   function automatic bit m_ok(int p, ins_t i);
      bit ok = 1'b1;
      if (i.srcs[2] && m_pend(i.a)) ok = 1'b0;
      if (i.srcs[1] && m_pend(i.b)) ok = 1'b0;
      if (i.srcs[0] && m_pend(i.c)) ok = 1'b0;
      if (i.we && (m_waw(i.rt) || m_busy(p, cyc + leff(i.lat)))) ok = 1'b0;
      return ok;
   endfunction

   function automatic ins_t rnd();
      ins_t i;
      i.v    = ($urandom_range(0, 3) != 0);
      i.a    = ADDR_W'($urandom_range(0, 7));
      i.b    = ADDR_W'($urandom_range(0, 7));
      i.c    = ADDR_W'($urandom_range(0, 7));
      i.srcs = 3'($urandom);
      i.rt   = ADDR_W'($urandom_range(0, 7));
      i.we   = ($urandom_range(0, 3) != 0);
      i.lat  = 3'($urandom_range(0, 7));
      return i;
   endfunction

   task automatic model_step(input ins_t ev, input ins_t od, output bit xei, output bit xoi);
      bit pair, rw0, rw1, idl;
      int a0, a1;
      xei  = ev.v && m_ok(0, ev);
      pair = xei && ev.we && ((od.srcs[2] && od.a == ev.rt) || (od.srcs[1] && od.b == ev.rt) ||
                              (od.srcs[0] && od.c == ev.rt) || (od.we && od.rt == ev.rt));
      xoi  = od.v && m_ok(1, od) && !pair && (!ev.v || xei);
      rw0 = 0; rw1 = 0; a0 = 0; a1 = 0; idl = 1;
      foreach (wq[i]) begin
         if (wq[i].due == cyc) begin
            if (wq[i].pipe == 0) begin rw0 = 1; a0 = int'(wq[i].addr); end
            else                 begin rw1 = 1; a1 = int'(wq[i].addr); end
         end
         if (wq[i].due >= cyc) idl = 0;
      end
      check_out("rand", xei, xoi, rw0, a0, rw1, a1, idl);
      if (xei && ev.we) wq.push_back('{0, cyc + leff(ev.lat), ev.rt});
      if (xoi && od.we) wq.push_back('{1, cyc + leff(od.lat), od.rt});
   endtask

   initial begin
      ins_t ev, od, o7, o9, es, os;
      bit   xei, xoi;

      // basic single write
      add(1, mk(1,0,0,5,1,4), '0, 1,0, 0,0, 0,0, 1);
      repeat (3) add(0, '0, '0, 0,0, 0,0, 0,0, 0);
      add(0, '0, '0, 0,0, 1,5, 0,0, 0);
      add(0, '0, '0, 0,0, 0,0, 0,0, 1);
      // RAW across pipes, bypassed on the commit cycle
      o7 = mk(1,5,3'b100,7,1,6);
      add(1, mk(1,0,0,5,1,4), '0, 1,0, 0,0, 0,0, 1);
      repeat (3) add(0, '0, o7, 0,0, 0,0, 0,0, 0);
      add(0, '0, o7, 0,1, 1,5, 0,0, 0);
      repeat (5) add(0, '0, '0, 0,0, 0,0, 0,0, 0);
      add(0, '0, '0, 0,0, 0,0, 1,7, 0);
      add(0, '0, '0, 0,0, 0,0, 0,0, 1);
      // intra-pair RAW
      o9 = mk(1,9,3'b100,10,1,1);
      add(1, mk(1,0,0,9,1,2), o9, 1,0, 0,0, 0,0, 1);
      add(0, '0, o9, 0,0, 0,0, 0,0, 0);
      add(0, '0, o9, 0,1, 1,9, 0,0, 0);
      add(0, '0, '0, 0,0, 0,0, 1,10, 0);
      add(0, '0, '0, 0,0, 0,0, 0,0, 1);
      // structural writeback-slot conflict
      add(1, mk(1,0,0,3,1,4), '0, 1,0, 0,0, 0,0, 1);
      add(0, mk(1,0,0,4,1,3), '0, 0,0, 0,0, 0,0, 0);
      add(0, mk(1,0,0,4,1,3), '0, 1,0, 0,0, 0,0, 0);
      add(0, '0, '0, 0,0, 0,0, 0,0, 0);
      add(0, '0, '0, 0,0, 1,3, 0,0, 0);
      add(0, '0, '0, 0,0, 1,4, 0,0, 0);
      add(0, '0, '0, 0,0, 0,0, 0,0, 1);
      // stalled even blocks a hazard-free odd
      es = mk(1,20,3'b100,21,1,1);
      os = mk(1,30,3'b100,31,1,1);
      add(1, mk(1,0,0,20,1,5), '0, 1,0, 0,0, 0,0, 1);
      repeat (4) add(0, es, os, 0,0, 0,0, 0,0, 0);
      add(0, es, os, 1,1, 1,20, 0,0, 0);
      add(0, '0, '0, 0,0, 1,21, 1,31, 0);
      add(0, '0, '0, 0,0, 0,0, 0,0, 1);
      // lat=0 acts as 1; intra-pair WAW
      add(1, mk(1,0,0,40,1,0), mk(1,0,0,40,1,1), 1,0, 0,0, 0,0, 1);
      add(0, '0, mk(1,0,0,40,1,1), 0,1, 1,40, 0,0, 0);
      add(0, '0, '0, 0,0, 0,0, 1,40, 0);
      add(0, '0, '0, 0,0, 0,0, 0,0, 1);
      // WAW, and rt_we=0 reserves nothing
      add(1, mk(1,0,0,50,1,3), '0, 1,0, 0,0, 0,0, 1);
      add(0, mk(1,0,0,50,0,1), '0, 1,0, 0,0, 0,0, 0);
      add(0, mk(1,0,0,50,1,4), '0, 0,0, 0,0, 0,0, 0);
      add(0, mk(1,0,0,50,1,4), '0, 1,0, 1,50, 0,0, 0);
      repeat (3) add(0, '0, '0, 0,0, 0,0, 0,0, 0);
      add(0, '0, '0, 0,0, 1,50, 0,0, 0);
      add(0, '0, '0, 0,0, 0,0, 0,0, 1);

      // reset state
      reset = 1'b0; e_in = '0; o_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_out("in_reset", 0,0, 0,0, 0,0, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_out($sformatf("post_reset%0d", i), 0,0, 0,0, 0,0, 1);
         @(posedge clk); #1;
      end

      foreach (vt[r]) begin
         if (vt[r].rst) do_reset();
         e_in = vt[r].e;
         o_in = vt[r].o;
         @(negedge clk);
         check_out($sformatf("row%0d", r), vt[r].ei, vt[r].oi, vt[r].rwe, vt[r].ae,
                   vt[r].rwo, vt[r].ao, vt[r].idl);
         @(posedge clk); #1;
      end

      // reset with three writes in flight
      do_reset();
      e_in = mk(1,0,0,60,1,6); o_in = mk(1,0,0,61,1,6);
      @(negedge clk);
      check_out("midrst_c0", 1,1, 0,0, 0,0, 1);
      @(posedge clk); #1;
      e_in = mk(1,0,0,62,1,7); o_in = '0;
      @(negedge clk);
      check_out("midrst_c1", 1,0, 0,0, 0,0, 0);
      @(posedge clk); #1;
      e_in = '0;
      @(negedge clk);
      check_out("midrst_c2", 0,0, 0,0, 0,0, 0);
      #1 reset = 1'b0;
      #1 check_out("midrst_async", 0,0, 0,0, 0,0, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check_out($sformatf("midrst_after%0d", i), 0,0, 0,0, 0,0, 1);
         @(posedge clk); #1;
      end

      // random traffic against the write-list model
      do_reset();
      wq.delete();
      cyc = 0;
      ev = rnd();
      od = rnd();
      for (int n = 0; n < 3000; n++) begin
         e_in = ev;
         o_in = od;
         @(negedge clk);
         model_step(ev, od, xei, xoi);
         @(posedge clk); #1;
         cyc++;
         for (int i = wq.size() - 1; i >= 0; i--)
            if (wq[i].due < cyc) wq.delete(i);
         if (!ev.v || xei) ev = rnd();
         if (!od.v || xoi) od = rnd();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
